// File: rtl/drbg_ctrl.sv
// CTR_DRBG command scheduler: checks preconditions, sequences engines over start/done, owns key/V/counter.
// Latency: checked-out cmds respond at cycle 2, engine ops one cycle after done; cmd_ready only in IDLE (host holds cmd_valid).
module drbg_ctrl #(
  parameter logic [31:0] RESEED_INTERVAL = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd_op,
  output logic         cmd_ready,
  output logic         inst_start,
  input  logic         inst_done,
  input  logic [255:0] inst_key,
  input  logic [127:0] inst_v,
  output logic         rsd_start,
  input  logic         rsd_done,
  input  logic [255:0] rsd_key,
  input  logic [127:0] rsd_v,
  output logic         gen_start,
  input  logic         gen_done,
  input  logic [255:0] gen_key,
  input  logic [127:0] gen_v,
  output logic [255:0] key,
  output logic [127:0] v,
  output logic [31:0]  reseed_counter,
  output logic         instantiated,
  output logic         resp_valid,
  output logic [1:0]   resp_status
);

  localparam logic [1:0] OP_INST   = 2'b00;
  localparam logic [1:0] OP_RSD    = 2'b01;
  localparam logic [1:0] OP_GEN    = 2'b10;
  localparam logic [1:0] OP_UNINST = 2'b11;

  localparam logic [1:0] STS_OK         = 2'b00;
  localparam logic [1:0] STS_NOT_INST   = 2'b01;
  localparam logic [1:0] STS_RESEED_REQ = 2'b10;
  localparam logic [1:0] STS_TIMEOUT    = 2'b11;

  localparam int unsigned   WDW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic             launch_q;
  logic [1:0]       pre_status_q;
  logic [WDW-1:0]   wd_cnt;

  logic             pre_launch;
  logic [1:0]       pre_status;
  logic             eng_done;
  logic [255:0]     eng_key;
  logic [127:0]     eng_v;

  assign cmd_ready = (state == ST_IDLE);

  // Working state is frozen while IDLE, so evaluating the checks at accept gives the same
  // verdict DISPATCH would, and lets the start pulse be a plain register during DISPATCH.
  always_comb begin
    pre_launch = 1'b0;
    pre_status = STS_OK;
    if ((cmd_op == OP_RSD || cmd_op == OP_GEN) && !instantiated) begin
      pre_status = STS_NOT_INST;
    end else if (cmd_op == OP_GEN && reseed_counter > RESEED_INTERVAL) begin
      pre_status = STS_RESEED_REQ;
    end else if (cmd_op != OP_UNINST) begin
      pre_launch = 1'b1;
    end
  end

  // Only the dispatched engine's done is listened to.
  always_comb begin
    eng_done = 1'b0;
    eng_key  = gen_key;
    eng_v    = gen_v;
    case (op_q)
      OP_INST: begin
        eng_done = inst_done;
        eng_key  = inst_key;
        eng_v    = inst_v;
      end
      OP_RSD: begin
        eng_done = rsd_done;
        eng_key  = rsd_key;
        eng_v    = rsd_v;
      end
      OP_GEN: begin
        eng_done = gen_done;
        eng_key  = gen_key;
        eng_v    = gen_v;
      end
      default: begin
        eng_done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      op_q           <= OP_INST;
      launch_q       <= 1'b0;
      pre_status_q   <= STS_OK;
      wd_cnt         <= '0;
      inst_start     <= 1'b0;
      rsd_start      <= 1'b0;
      gen_start      <= 1'b0;
      key            <= '0;
      v              <= '0;
      reseed_counter <= '0;
      instantiated   <= 1'b0;
      resp_valid     <= 1'b0;
      resp_status    <= STS_OK;
    end else begin
      inst_start <= 1'b0;
      rsd_start  <= 1'b0;
      gen_start  <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q         <= cmd_op;
            launch_q     <= pre_launch;
            pre_status_q <= pre_status;
            inst_start   <= pre_launch && (cmd_op == OP_INST);
            rsd_start    <= pre_launch && (cmd_op == OP_RSD);
            gen_start    <= pre_launch && (cmd_op == OP_GEN);
            state        <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          wd_cnt <= '0;
          if (launch_q) begin
            state <= ST_WAIT;
          end else begin
            if (op_q == OP_UNINST) begin
              key            <= '0;
              v              <= '0;
              reseed_counter <= '0;
              instantiated   <= 1'b0;
            end
            resp_valid  <= 1'b1;
            resp_status <= pre_status_q;
            state       <= ST_RESP;
          end
        end
        ST_WAIT: begin
          // A done arriving in the expiry cycle takes precedence over the watchdog.
          if (eng_done) begin
            key <= eng_key;
            v   <= eng_v;
            if (op_q == OP_GEN) begin
              if (reseed_counter != 32'hFFFF_FFFF) begin
                reseed_counter <= reseed_counter + 32'd1;
              end
            end else begin
              reseed_counter <= 32'd1;
            end
            if (op_q == OP_INST) begin
              instantiated <= 1'b1;
            end
            resp_valid  <= 1'b1;
            resp_status <= STS_OK;
            state       <= ST_RESP;
          end else if (wd_cnt == WD_LAST) begin
            key            <= '0;
            v              <= '0;
            reseed_counter <= '0;
            instantiated   <= 1'b0;
            resp_valid     <= 1'b1;
            resp_status    <= STS_TIMEOUT;
            state          <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  a_start_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({inst_start, rsd_start, gen_start}));
  a_resp_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid |-> (state == ST_RESP));
  a_start_in_dispatch: assert property (@(posedge clk) disable iff (!rst_n)
    (inst_start | rsd_start | gen_start) |-> (state == ST_DISPATCH));

endmodule

// File: tb/tb_drbg_ctrl.sv
// Bench for drbg_ctrl: directed scenarios plus randomized command streams against a behavioural model.
module tb_drbg_ctrl;

  localparam int TO = 8;
  localparam logic [31:0] RI = 32'd2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic         cmd_ready;
  logic         inst_start, rsd_start, gen_start;
  logic         inst_done = 1'b0, rsd_done = 1'b0, gen_done = 1'b0;
  logic [255:0] inst_key = '0, rsd_key = '0, gen_key = '0;
  logic [127:0] inst_v = '0, rsd_v = '0, gen_v = '0;
  logic [255:0] key;
  logic [127:0] v;
  logic [31:0]  reseed_counter;
  logic         instantiated;
  logic         resp_valid;
  logic [1:0]   resp_status;

  int tests = 0;
  int fails = 0;

  // observations from the last command
  int           o_ready0, o_resp_cyc, o_st_cyc, n_inst_st, n_rsd_st, n_gen_st;
  int           o_busy_ready, o_extra_resp, o_idle_after;
  logic [1:0]   o_status;
  logic [255:0] o_key;
  logic [127:0] o_v;
  logic [31:0]  o_cnt;
  logic         o_inst;

  // reference model state and expectations
  logic [255:0] m_key;
  logic [127:0] m_v;
  logic [31:0]  m_cnt;
  logic         m_inst;
  int           e_resp, e_launch;
  logic [1:0]   e_status;

  drbg_ctrl #(.RESEED_INTERVAL(RI), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .inst_start(inst_start), .inst_done(inst_done), .inst_key(inst_key), .inst_v(inst_v),
    .rsd_start(rsd_start), .rsd_done(rsd_done), .rsd_key(rsd_key), .rsd_v(rsd_v),
    .gen_start(gen_start), .gen_done(gen_done), .gen_key(gen_key), .gen_v(gen_v),
    .key(key), .v(v), .reseed_counter(reseed_counter), .instantiated(instantiated),
    .resp_valid(resp_valid), .resp_status(resp_status)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] r256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic new_engine_data();
    inst_key = r256(); rsd_key = r256(); gen_key = r256();
    inst_v = r256()[127:0]; rsd_v = r256()[127:0]; gen_v = r256()[127:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // dly: done asserted at cycle 1+dly (0 = withheld); stray pulses the other engines at cycle 3
  task automatic run_cmd(input logic [1:0] op, input int dly, input bit stray);
    o_resp_cyc = -1; o_st_cyc = -1; n_inst_st = 0; n_rsd_st = 0; n_gen_st = 0;
    o_busy_ready = 0; o_extra_resp = 0; o_idle_after = 0;
    @(negedge clk);
    o_ready0 = int'(cmd_ready);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (inst_start) begin n_inst_st++; o_st_cyc = cyc; end
      if (rsd_start)  begin n_rsd_st++;  o_st_cyc = cyc; end
      if (gen_start)  begin n_gen_st++;  o_st_cyc = cyc; end
      if (resp_valid) begin
        if (o_resp_cyc < 0) begin
          o_resp_cyc = cyc; o_status = resp_status; o_key = key; o_v = v;
          o_cnt = reseed_counter; o_inst = instantiated;
        end else begin
          o_extra_resp++;
        end
      end
      if (cmd_ready && o_resp_cyc < 0) o_busy_ready = 1;
      if (o_resp_cyc >= 0 && cyc > o_resp_cyc) begin
        o_idle_after = int'(cmd_ready && !resp_valid);
        inst_done = 1'b0; rsd_done = 1'b0; gen_done = 1'b0;
        break;
      end
      inst_done = (dly != 0 && cyc == 1 + dly && op == 2'b00) || (stray && cyc == 3 && op != 2'b00);
      rsd_done  = (dly != 0 && cyc == 1 + dly && op == 2'b01) || (stray && cyc == 3 && op != 2'b01);
      gen_done  = (dly != 0 && cyc == 1 + dly && op == 2'b10) || (stray && cyc == 3 && op != 2'b10);
      @(negedge clk);
    end
    inst_done = 1'b0; rsd_done = 1'b0; gen_done = 1'b0;
  endtask

  // Behavioural model of one command: precondition rules, then engine completion or watchdog expiry.
  task automatic model_cmd(input logic [1:0] op, input int dly);
    e_launch = 0; e_status = 2'b00; e_resp = 2;
    if ((op == 2'b01 || op == 2'b10) && !m_inst) begin
      e_status = 2'b01;
    end else if (op == 2'b10 && m_cnt > RI) begin
      e_status = 2'b10;
    end else if (op == 2'b11) begin
      m_key = '0; m_v = '0; m_cnt = '0; m_inst = 1'b0;
    end else begin
      e_launch = 1;
      if (dly >= 1 && dly <= TO) begin
        e_resp = dly + 2;
        case (op)
          2'b00: begin m_key = inst_key; m_v = inst_v; m_cnt = 32'd1; m_inst = 1'b1; end
          2'b01: begin m_key = rsd_key; m_v = rsd_v; m_cnt = 32'd1; end
          default: begin
            m_key = gen_key; m_v = gen_v;
            m_cnt = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
          end
        endcase
      end else begin
        e_status = 2'b11; e_resp = TO + 2;
        m_key = '0; m_v = '0; m_cnt = '0; m_inst = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (key !== '0) begin fails++; $display("FAIL reset_key: got %0h want 0", key); end
    tests++; if (v !== '0) begin fails++; $display("FAIL reset_v: got %0h want 0", v); end
    tests++; if (reseed_counter !== 32'd0) begin fails++; $display("FAIL reset_cnt: got %0h want 0", reseed_counter); end
    tests++; if (instantiated !== 1'b0) begin fails++; $display("FAIL reset_inst: got %b want 0", instantiated); end
    tests++; if ({resp_valid, inst_start, rsd_start, gen_start} !== 4'b0) begin
      fails++; $display("FAIL reset_pulses: got %b want 0000", {resp_valid, inst_start, rsd_start, gen_start}); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_generate_not_inst();
    run_cmd(2'b10, 3, 1'b0);
    tests++; if (n_gen_st !== 0) begin fails++; $display("FAIL ni_gen_start: got %0d want 0", n_gen_st); end
    tests++; if (o_resp_cyc !== 2) begin fails++; $display("FAIL ni_resp_cycle: got %0d want 2", o_resp_cyc); end
    tests++; if (o_status !== 2'b01) begin fails++; $display("FAIL ni_status: got %0h want 1", o_status); end
    tests++; if (o_inst !== 1'b0) begin fails++; $display("FAIL ni_inst: got %b want 0", o_inst); end
  endtask

  task automatic test_instantiate();
    logic [255:0] k;
    logic [127:0] vv;
    new_engine_data();
    k = inst_key; vv = inst_v;
    run_cmd(2'b00, 5, 1'b0);
    tests++; if (o_ready0 !== 1 || o_busy_ready !== 0) begin
      fails++; $display("FAIL inst_ready: got ready0=%0d busy=%0d want 1/0", o_ready0, o_busy_ready); end
    tests++; if (n_inst_st !== 1 || o_st_cyc !== 1) begin
      fails++; $display("FAIL inst_start: got n=%0d cyc=%0d want 1/1", n_inst_st, o_st_cyc); end
    tests++; if (o_resp_cyc !== 7 || o_status !== 2'b00) begin
      fails++; $display("FAIL inst_resp: got cyc=%0d st=%0h want 7/0", o_resp_cyc, o_status); end
    tests++; if (o_key !== k || o_v !== vv) begin fails++; $display("FAIL inst_keyv: got %0h/%0h want %0h/%0h", o_key, o_v, k, vv); end
    tests++; if (o_cnt !== 32'd1 || o_inst !== 1'b1) begin
      fails++; $display("FAIL inst_state: got cnt=%0h inst=%b want 1/1", o_cnt, o_inst); end
    tests++; if (o_idle_after !== 1 || o_extra_resp !== 0) begin
      fails++; $display("FAIL inst_idle: got idle=%0d extra=%0d want 1/0", o_idle_after, o_extra_resp); end
  endtask

  task automatic test_reseed_interval();
    logic [255:0] k;
    run_cmd(2'b10, 3, 1'b0);
    tests++; if (o_status !== 2'b00 || o_cnt !== 32'd2) begin
      fails++; $display("FAIL ri_gen1: got st=%0h cnt=%0h want 0/2", o_status, o_cnt); end
    new_engine_data();
    run_cmd(2'b10, 1, 1'b0);
    tests++; if (o_status !== 2'b00 || o_cnt !== 32'd3 || o_resp_cyc !== 3) begin
      fails++; $display("FAIL ri_gen2: got st=%0h cnt=%0h cyc=%0d want 0/3/3", o_status, o_cnt, o_resp_cyc); end
    k = gen_key;
    new_engine_data();
    run_cmd(2'b10, 2, 1'b0);
    tests++; if (o_status !== 2'b10 || n_gen_st !== 0 || o_resp_cyc !== 2) begin
      fails++; $display("FAIL ri_gen3: got st=%0h starts=%0d cyc=%0d want 2/0/2", o_status, n_gen_st, o_resp_cyc); end
    tests++; if (o_key !== k || o_cnt !== 32'd3) begin fails++; $display("FAIL ri_hold: got cnt=%0h want 3", o_cnt); end
    k = rsd_key;
    run_cmd(2'b01, 2, 1'b0);
    tests++; if (o_status !== 2'b00 || o_cnt !== 32'd1 || o_key !== k || n_rsd_st !== 1) begin
      fails++; $display("FAIL ri_reseed: got st=%0h cnt=%0h starts=%0d want 0/1/1", o_status, o_cnt, n_rsd_st); end
    k = gen_key;
    run_cmd(2'b10, 4, 1'b0);
    tests++; if (o_status !== 2'b00 || o_cnt !== 32'd2 || o_key !== k) begin
      fails++; $display("FAIL ri_gen4: got st=%0h cnt=%0h want 0/2", o_status, o_cnt); end
  endtask

  task automatic test_timeout();
    run_cmd(2'b10, 0, 1'b1);
    tests++; if (o_status !== 2'b11 || o_resp_cyc !== TO + 2) begin
      fails++; $display("FAIL to_resp: got st=%0h cyc=%0d want 3/%0d", o_status, o_resp_cyc, TO + 2); end
    tests++; if (o_key !== '0 || o_v !== '0 || o_cnt !== '0 || o_inst !== 1'b0) begin
      fails++; $display("FAIL to_zero: got cnt=%0h inst=%b want 0/0", o_cnt, o_inst); end
  endtask

  task automatic test_watchdog_edge();
    new_engine_data();
    run_cmd(2'b00, TO, 1'b0);
    tests++; if (o_status !== 2'b00 || o_resp_cyc !== TO + 2 || o_key !== inst_key) begin
      fails++; $display("FAIL wd_last_done: got st=%0h cyc=%0d want 0/%0d", o_status, o_resp_cyc, TO + 2); end
    run_cmd(2'b10, TO + 1, 1'b0);
    tests++; if (o_status !== 2'b11 || o_inst !== 1'b0) begin
      fails++; $display("FAIL wd_late_done: got st=%0h inst=%b want 3/0", o_status, o_inst); end
  endtask

  task automatic test_uninstantiate();
    new_engine_data();
    run_cmd(2'b00, 2, 1'b0);
    run_cmd(2'b11, 3, 1'b1);
    tests++; if (o_status !== 2'b00 || o_resp_cyc !== 2) begin
      fails++; $display("FAIL un_resp: got st=%0h cyc=%0d want 0/2", o_status, o_resp_cyc); end
    tests++; if (n_inst_st + n_rsd_st + n_gen_st !== 0) begin
      fails++; $display("FAIL un_starts: got %0d want 0", n_inst_st + n_rsd_st + n_gen_st); end
    tests++; if (o_key !== '0 || o_v !== '0 || o_cnt !== '0 || o_inst !== 1'b0) begin
      fails++; $display("FAIL un_zero: got cnt=%0h inst=%b want 0/0", o_cnt, o_inst); end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    new_engine_data();
    run_cmd(2'b00, 2, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (key !== '0 || v !== '0 || reseed_counter !== '0 || instantiated !== 1'b0) begin
      fails++; $display("FAIL rw_zero: got cnt=%0h inst=%b want 0/0", reseed_counter, instantiated); end
    tests++; if ({resp_valid, gen_start} !== 2'b00) begin
      fails++; $display("FAIL rw_pulses: got %b want 00", {resp_valid, gen_start}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
    seen = 0;
    repeat (6) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0 || cmd_ready !== 1'b1 || instantiated !== 1'b0) begin
      fails++; $display("FAIL rw_late_done: got resp=%0d ready=%b want 0/1", seen, cmd_ready); end
  endtask

  task automatic test_random();
    logic [1:0] op;
    int dly;
    bit stray;
    do_reset();
    m_key = '0; m_v = '0; m_cnt = '0; m_inst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      op = (m_inst == 1'b0 && $urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 1));
      stray = 1'($urandom_range(0, 1));
      new_engine_data();
      model_cmd(op, dly);
      run_cmd(op, dly, stray);
      tests++; if (o_status !== e_status || o_resp_cyc !== e_resp) begin
        fails++; $display("FAIL rnd%0d_resp op=%0d dly=%0d: got st=%0h cyc=%0d want %0h/%0d",
                          n, op, dly, o_status, o_resp_cyc, e_status, e_resp); end
      tests++; if (n_inst_st !== int'(e_launch == 1 && op == 2'b00) || n_rsd_st !== int'(e_launch == 1 && op == 2'b01) ||
                   n_gen_st !== int'(e_launch == 1 && op == 2'b10) || o_st_cyc !== (e_launch == 1 ? 1 : -1)) begin
        fails++; $display("FAIL rnd%0d_starts op=%0d: got i/r/g=%0d/%0d/%0d cyc=%0d want launch=%0d",
                          n, op, n_inst_st, n_rsd_st, n_gen_st, o_st_cyc, e_launch); end
      tests++; if (o_key !== m_key || o_v !== m_v) begin
        fails++; $display("FAIL rnd%0d_keyv: got %0h/%0h want %0h/%0h", n, o_key, o_v, m_key, m_v); end
      tests++; if (o_cnt !== m_cnt || o_inst !== m_inst) begin
        fails++; $display("FAIL rnd%0d_state: got cnt=%0h inst=%b want %0h/%b", n, o_cnt, o_inst, m_cnt, m_inst); end
      tests++; if (o_ready0 !== 1 || o_busy_ready !== 0 || o_idle_after !== 1 || o_extra_resp !== 0) begin
        fails++; $display("FAIL rnd%0d_handshake: got ready0=%0d busy=%0d idle=%0d extra=%0d want 1/0/1/0",
                          n, o_ready0, o_busy_ready, o_idle_after, o_extra_resp); end
    end
  endtask

  initial begin
    test_reset();
    test_generate_not_inst();
    test_instantiate();
    test_reseed_interval();
    test_timeout();
    test_watchdog_edge();
    test_uninstantiate();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule
